// File: rtl/multdiv_sched_pkg.sv
// multdiv_sched_pkg: instruction field slices, opcode/aluop constants, scheduler
// timing parameters and the IDLE/BUSY/HOLD state encoding.
package multdiv_sched_pkg;
  localparam logic [3:0] MIN_LAT = 4'd3;
  localparam logic [3:0] HOLD_LIMIT = 4'd4;
  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [31:0] MUL_EXC = 32'd4;
  localparam logic [31:0] DIV_EXC = 32'd5;
  localparam logic [4:0] OP_ALU = 5'd0, OP_J = 5'd1, OP_BNE = 5'd2, OP_JAL = 5'd3, OP_JR = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5, OP_BLT = 5'd6, OP_SW = 5'd7, OP_LW = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21, OP_BEX = 5'd22;
  localparam logic [4:0] ALU_MUL = 5'd6, ALU_DIV = 5'd7;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  function automatic logic [4:0] f_op(input logic [31:0] i);
    return i[31:27];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[26:22];
  endfunction
  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[21:17];
  endfunction
  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[16:12];
  endfunction
  function automatic logic [4:0] f_alu(input logic [31:0] i);
    return i[6:2];
  endfunction
  function automatic logic is_md(input logic [31:0] i);
    return f_op(i) == OP_ALU && (f_alu(i) == ALU_MUL || f_alu(i) == ALU_DIV);
  endfunction
  function automatic logic [31:0] reg_bit(input logic [4:0] r);
    return 32'd1 << r;
  endfunction
endpackage

// File: rtl/md_hazard_check.sv
// md_hazard_check: flags an instruction that reads or writes any register in the
// pending mask; r0 never creates a hazard.
module md_hazard_check
  import multdiv_sched_pkg::*;
(
  input  logic [31:0] insn,
  input  logic [31:0] pend,
  output logic        hit
);
  logic [31:0] use_mask;
  always_comb begin
    use_mask = '0;
    case (f_op(insn))
      OP_ALU: use_mask = reg_bit(f_rd(insn)) | reg_bit(f_rs(insn)) | reg_bit(f_rt(insn));
      OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT: use_mask = reg_bit(f_rd(insn)) | reg_bit(f_rs(insn));
      OP_JR: use_mask = reg_bit(f_rd(insn));
      OP_JAL: use_mask = reg_bit(5'd31);
      OP_SETX, OP_BEX: use_mask = reg_bit(RSTATUS_REG);
      default: use_mask = '0;
    endcase
  end
  assign hit = |(use_mask & pend & ~32'd1);
endmodule

// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler: issues mul/div to the shared multdiv unit, stalls FD on hazards
// and merges the late result into the single regfile write port. MULTDIV_EXCEPTION_EN
// redirects an excepting result to the rstatus register.
module multdiv_scheduler
  import multdiv_sched_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic        mw_we,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_data,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);
  state_t state;
  logic [4:0] rd_q, pend_rd, tgt;
  logic [31:0] res_q, pend, val;
  logic [3:0] cnt, wcnt;
  logic div_q, exc_q, force_q, issue, pend_v, commit, hit;
  assign issue = state == IDLE && is_md(dx_insn);
  assign pend_v = issue || state != IDLE;
  assign pend_rd = state == IDLE ? f_rd(dx_insn) : rd_q;
`ifdef MULTDIV_EXCEPTION_EN
  assign pend = pend_v ? reg_bit(pend_rd) | reg_bit(RSTATUS_REG) : '0;
  assign tgt = exc_q ? RSTATUS_REG : rd_q;
  assign val = exc_q ? (div_q ? DIV_EXC : MUL_EXC) : res_q;
`else
  logic unused_exc;
  assign unused_exc = exc_q ^ div_q;
  assign pend = pend_v ? reg_bit(pend_rd) : '0;
  assign tgt = rd_q;
  assign val = res_q;
`endif
  md_hazard_check u_fd_hazard (.insn(fd_insn), .pend(pend), .hit(hit));
  // the pending MW write always wins the port; the buffered result waits
  assign commit = state == HOLD && cnt >= MIN_LAT && (!mw_we || mw_rd == 5'd0);
  assign ctrl_mult = reset && issue && f_alu(dx_insn) == ALU_MUL;
  assign ctrl_div = reset && issue && f_alu(dx_insn) == ALU_DIV;
  assign stall = reset && (hit || (is_md(fd_insn) && pend_v) || force_q);
  assign rf_we = reset && (commit ? tgt != 5'd0 : mw_we && mw_rd != 5'd0);
  assign rf_rd = !reset ? '0 : commit ? tgt : mw_rd;
  assign rf_data = !reset ? '0 : commit ? val : mw_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rd_q <= '0;
      res_q <= '0;
      div_q <= 1'b0;
      exc_q <= 1'b0;
      cnt <= '0;
      wcnt <= '0;
      force_q <= 1'b0;
    end else begin
      cnt <= issue ? '0 : cnt < MIN_LAT ? cnt + 4'd1 : cnt;
      case (state)
        IDLE: if (issue) begin
          state <= BUSY;
          rd_q <= f_rd(dx_insn);
          div_q <= f_alu(dx_insn) == ALU_DIV;
        end
        BUSY: if (md_ready) begin
          state <= HOLD;
          res_q <= md_result;
          exc_q <= md_exception;
          wcnt <= '0;
        end
        default: if (commit) begin
          state <= IDLE;
          wcnt <= '0;
          force_q <= 1'b0;
        end else begin
          wcnt <= wcnt < HOLD_LIMIT ? wcnt + 4'd1 : wcnt;
          if (wcnt + 4'd1 >= HOLD_LIMIT) force_q <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_multdiv_scheduler.sv
// tb_multdiv_scheduler: directed scenarios plus randomized mul/div sequences checked
// against a cycle-timeline model of issue, latency, write-port arbitration and stall.
module tb_multdiv_scheduler;
  logic clock = 1'b0, reset = 1'b0;
  logic [31:0] fd_insn, dx_insn, md_result, mw_data, rf_data;
  logic md_ready, md_exception, mw_we, ctrl_mult, ctrl_div, stall, rf_we;
  logic [4:0] mw_rd, rf_rd;
  int errors = 0, checks = 0;
  localparam logic [31:0] NOP = 32'd0;
  localparam int MIN_LAT = 3, HOLD_LIMIT = 4;
`ifdef MULTDIV_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  multdiv_scheduler dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data), .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div), .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  function automatic logic [31:0] rtype(input int alu, input int d, input int s, input int t);
    return {5'd0, 5'(d), 5'(s), 5'(t), 5'd0, 5'(alu), 2'b00};
  endfunction
  function automatic logic [31:0] itype(input int op, input int d, input int s);
    return {5'(op), 5'(d), 5'(s), 17'($urandom)};
  endfunction
  // register usage of an instruction, from the ISA operand rules
  function automatic bit touches(input logic [31:0] i, input int r);
    int op, d, s, t;
    op = int'(i[31:27]); d = int'(i[26:22]); s = int'(i[21:17]); t = int'(i[16:12]);
    if (op == 0) return r == d || r == s || r == t;
    if (op inside {2, 5, 6, 7, 8}) return r == d || r == s;
    if (op == 4) return r == d;
    if (op == 3) return r == 31;
    if (op inside {21, 22}) return r == 30;
    return 1'b0;
  endfunction
  function automatic bit md_op(input logic [31:0] i);
    return i[31:27] == 5'd0 && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
  endfunction
  function automatic bit hazard(input logic [31:0] i, input int d);
    return (d != 0 && touches(i, d)) || (EXC_EN && touches(i, 30));
  endfunction
  function automatic int exp_rd(input int d, input bit exc);
    return EXC_EN && exc ? 30 : d;
  endfunction
  function automatic logic [31:0] exp_val(input logic [31:0] res, input bit exc, input bit div);
    return EXC_EN && exc ? (div ? 32'd5 : 32'd4) : res;
  endfunction
  function automatic logic [31:0] rand_insn(input int d);
    int a, b, c;
    int iops[5] = '{2, 5, 6, 7, 8};
    int oops[5] = '{1, 3, 4, 21, 22};
    a = $urandom_range(0, 1) ? d : $urandom_range(0, 31);
    b = $urandom_range(0, 1) ? d : $urandom_range(0, 31);
    c = $urandom_range(0, 31);
    case ($urandom_range(0, 4))
      0: return rtype(0, a, b, c);
      1: return rtype($urandom_range(6, 7), a, b, c);
      2: return itype(iops[$urandom_range(0, 4)], a, b);
      3: return itype(oops[$urandom_range(0, 4)], a, b);
      default: return NOP;
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle_inputs;
    fd_insn = NOP; dx_insn = NOP; md_result = '0; md_ready = 1'b0; md_exception = 1'b0;
    mw_we = 1'b0; mw_rd = '0; mw_data = '0;
  endtask

  task automatic test_reset;
    dx_insn = rtype(6, 3, 1, 2); fd_insn = rtype(7, 4, 3, 1); md_ready = 1'b1;
    md_result = 32'h1234_5678; md_exception = 1'b1;
    mw_we = 1'b1; mw_rd = 5'd9; mw_data = 32'hdead_beef;
    #12;
    checks++;
    if ({ctrl_mult, ctrl_div, stall, rf_we, rf_rd, rf_data} !== '0)
      begin errors++; $display("FAIL reset outputs got %b%b%b%b rd=%0d data=%h want all 0", ctrl_mult, ctrl_div, stall, rf_we, rf_rd, rf_data); end
    tick;
    idle_inputs;
    reset = 1'b1;
  endtask

  task automatic test_issue;
    logic [31:0] r;
    r = $urandom;
    for (int k = 0; k <= 5; k++) begin
      tick; idle_inputs;
      dx_insn = k <= 1 ? rtype(6, 3, 1, 2) : NOP;
      fd_insn = rtype(0, 5, 6, 7);
      md_ready = k == 1; md_result = r;
      #2;
      checks++;
      if ({ctrl_mult, ctrl_div, stall} !== {k == 0, 1'b0, 1'b0})
        begin errors++; $display("FAIL issue ctrl k=%0d got mult=%b div=%b stall=%b want mult=%b", k, ctrl_mult, ctrl_div, stall, k == 0); end
      checks++;
      if ({rf_we, rf_rd, rf_data} !== (k == 4 ? {1'b1, 5'd3, r} : 38'd0))
        begin errors++; $display("FAIL issue commit k=%0d got we=%b rd=%0d data=%h", k, rf_we, rf_rd, rf_data); end
    end
  endtask

  task automatic test_dependent;
    int writes = 0;
    logic [31:0] r;
    r = $urandom;
    for (int k = 0; k <= 5; k++) begin
      tick; idle_inputs;
      dx_insn = k == 0 ? rtype(6, 3, 1, 2) : NOP;
      fd_insn = rtype(0, 4, 3, 1);
      md_ready = k == 1; md_result = r;
      #2;
      if (rf_we && rf_rd == 5'd3) writes++;
      checks++;
      if (stall !== (k <= 4))
        begin errors++; $display("FAIL dependent stall k=%0d got %b want %b", k, stall, k <= 4); end
    end
    checks++;
    if (writes != 1) begin errors++; $display("FAIL dependent r3 writes got %0d want 1", writes); end
  endtask

  task automatic test_min_latency;
    logic [31:0] r;
    r = $urandom;
    for (int k = 0; k <= 5; k++) begin
      tick; idle_inputs;
      dx_insn = k == 0 ? rtype(6, 3, 1, 2) : NOP;
      md_ready = k == 2; md_result = r;
      #2;
      checks++;
      if ({rf_we, rf_rd, rf_data} !== (k == 4 ? {1'b1, 5'd3, r} : 38'd0))
        begin errors++; $display("FAIL min_latency k=%0d got we=%b rd=%0d data=%h want we=%b", k, rf_we, rf_rd, rf_data, k == 4); end
    end
  endtask

  task automatic test_hold_limit;
    logic [31:0] r, d;
    r = $urandom;
    for (int k = 0; k <= 12; k++) begin
      tick; idle_inputs;
      d = $urandom;
      dx_insn = k == 0 ? rtype(6, 3, 1, 2) : NOP;
      fd_insn = rtype(0, 5, 6, 7);
      md_ready = k == 4; md_result = r;
      mw_we = k >= 5 && k <= 10; mw_rd = 5'd9; mw_data = d;
      #2;
      checks++;
      if ({rf_we, rf_rd, rf_data} !== (k == 11 ? {1'b1, 5'd3, r} : {k >= 5 && k <= 10, 5'd9, d}))
        begin errors++; $display("FAIL hold_limit port k=%0d got we=%b rd=%0d data=%h", k, rf_we, rf_rd, rf_data); end
      checks++;
      if (stall !== (k >= 9 && k <= 11))
        begin errors++; $display("FAIL hold_limit stall k=%0d got %b want %b", k, stall, k >= 9 && k <= 11); end
    end
  endtask

  task automatic test_exception;
    logic [31:0] r;
    int t;
    for (int div = 0; div <= 1; div++) begin
      r = $urandom;
      t = exp_rd(3, 1'b1);
      for (int k = 0; k <= 5; k++) begin
        tick; idle_inputs;
        dx_insn = k == 0 ? rtype(6 + div, 3, 1, 0) : NOP;
        fd_insn = k == 2 ? itype(22, 0, 0) : rtype(0, 5, 6, 7);
        md_ready = k == 1; md_result = r; md_exception = 1'b1;
        #2;
        checks++;
        if ({rf_we, rf_rd, rf_data} !== (k == 4 ? {1'b1, 5'(t), exp_val(r, 1'b1, div[0])} : 38'd0))
          begin errors++; $display("FAIL exception div=%0d k=%0d got we=%b rd=%0d data=%h want rd=%0d", div, k, rf_we, rf_rd, rf_data, t); end
        checks++;
        if (stall !== (k == 2 && EXC_EN))
          begin errors++; $display("FAIL exception stall div=%0d k=%0d got %b", div, k, stall); end
      end
    end
  endtask

  task automatic test_reset_midop;
    tick; idle_inputs;
    dx_insn = rtype(6, 3, 1, 2);
    #2;
    checks++;
    if (ctrl_mult !== 1'b1) begin errors++; $display("FAIL midop issue got %b want 1", ctrl_mult); end
    tick;
    dx_insn = NOP; fd_insn = rtype(7, 4, 3, 1);
    mw_we = 1'b1; mw_rd = 5'd9; mw_data = $urandom;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ctrl_mult, ctrl_div, stall, rf_we, rf_rd, rf_data} !== '0)
      begin errors++; $display("FAIL midop reset outputs got stall=%b we=%b rd=%0d data=%h want all 0", stall, rf_we, rf_rd, rf_data); end
    tick;
    reset = 1'b1;
    mw_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      fd_insn = rtype(0, 4, 3, 1);
      md_ready = k == 1; md_result = $urandom;
      #2;
      checks++;
      if ({rf_we, stall} !== 2'b00)
        begin errors++; $display("FAIL midop after reset k=%0d got we=%b stall=%b want 0 0", k, rf_we, stall); end
    end
    idle_inputs;
  endtask

  task automatic test_random;
    bit div, exc, is_commit;
    int d, ready, commit, t, start;
    logic [31:0] res, fd;
    logic [37:0] exp_rf;
    for (int n = 0; n < 40; n++) begin
      div = 1'($urandom_range(0, 1)); exc = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 31); ready = $urandom_range(1, 6);
      res = $urandom; commit = -1; t = exp_rd(d, exc);
      start = ready + 1 > MIN_LAT + 1 ? ready + 1 : MIN_LAT + 1;
      for (int k = 0; commit < 0 || k <= commit + 1; k++) begin
        if (k > 45) begin
          errors++; checks++;
          $display("FAIL random op %0d no commit within 45 cycles", n);
          break;
        end
        tick;
        dx_insn = k == 0 ? rtype(div ? 7 : 6, d, $urandom_range(0, 31), $urandom_range(0, 31)) : NOP;
        fd = rand_insn(d); fd_insn = fd;
        md_ready = k == ready || (k > ready && $urandom_range(0, 3) == 0);
        md_result = k == ready ? res : $urandom;
        md_exception = k == ready ? exc : 1'($urandom_range(0, 1));
        mw_we = 1'($urandom_range(0, 1));
        mw_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
        mw_data = $urandom;
        #2;
        is_commit = commit < 0 && k >= start && (!mw_we || mw_rd == 5'd0);
        exp_rf = is_commit ? {t != 0, 5'(t), exp_val(res, exc, div)} : {mw_we && mw_rd != 5'd0, mw_rd, mw_data};
        checks++;
        if ({ctrl_mult, ctrl_div} !== {k == 0 && !div, k == 0 && div})
          begin errors++; $display("FAIL random ctrl op %0d k=%0d got %b%b div=%b", n, k, ctrl_mult, ctrl_div, div); end
        checks++;
        if (stall !== (commit < 0 && (hazard(fd, d) || md_op(fd) || (k > ready && k - ready - 1 >= HOLD_LIMIT))))
          begin errors++; $display("FAIL random stall op %0d k=%0d rd=%0d fd=%h got %b", n, k, d, fd, stall); end
        checks++;
        if ({rf_we, rf_rd, rf_data} !== exp_rf)
          begin errors++; $display("FAIL random port op %0d k=%0d got %b/%0d/%h want %b/%0d/%h", n, k, rf_we, rf_rd, rf_data, exp_rf[37], exp_rf[36:32], exp_rf[31:0]); end
        if (is_commit) commit = k;
      end
    end
    idle_inputs;
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_issue;
    test_dependent;
    test_min_latency;
    test_hold_limit;
    test_exception;
    test_reset_midop;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
